// File: rtl/bht_sched.sv
// bht_sched: clears a branch history table after reset/flush, then serialises EXE
// branch resolutions into it through a small update queue. Optional macro
// BHT_SCHED_BYPASS_EN writes an update in its arrival cycle when the queue is empty.
module bht_sched #(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic             upd_valid,
  input  logic [9:0]       upd_PC,
  input  logic             upd_taken,
  input  logic [9:0]       upd_target,
  output logic             upd_ready,
  input  logic             flush_req,
  output logic [IDX_W-1:0] tbl_raddr,
  input  logic [1:0]       tbl_rctr,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_waddr,
  output logic [1:0]       tbl_wctr,
  output logic             tbl_wtgt_en,
  output logic [9:0]       tbl_wtgt,
  output logic             tbl_wvalid,
  output logic             pred_en
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] last_raddr;

  // Only the table index of the PC is ever needed downstream.
  logic [IDX_W-1:0] q_idx   [FIFO_DEPTH];
  logic             q_taken [FIFO_DEPTH];
  logic [9:0]       q_tgt   [FIFO_DEPTH];

  logic pc_hi_unused;
  assign pc_hi_unused = ^upd_PC[9:IDX_W];

  logic in_run, in_init, fifo_empty, fifo_full;
  logic accept, push, pop, byp, drain;
  logic [IDX_W-1:0] upd_idx, sel_idx;
  logic             sel_taken;
  logic [9:0]       sel_tgt;
  logic [1:0]       ctr_next;

  assign in_run     = (state == S_RUN);
  assign in_init    = (state == S_INIT);
  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == CNT_W'(FIFO_DEPTH));
  assign upd_idx    = upd_PC[IDX_W-1:0];

  assign upd_ready = in_run && !fifo_full && !flush_req;
  assign accept    = upd_valid && upd_ready;
  assign pop       = in_run && !fifo_empty;
  assign pred_en   = in_run;

`ifdef BHT_SCHED_BYPASS_EN
  assign byp = accept && fifo_empty;
`else
  assign byp = 1'b0;
`endif

  assign push  = accept && !byp;
  assign drain = pop || byp;

  // Queue head has priority; bypass only fires when the queue is empty.
  always_comb begin
    sel_idx   = q_idx[rd_ptr];
    sel_taken = q_taken[rd_ptr];
    sel_tgt   = q_tgt[rd_ptr];
    if (byp) begin
      sel_idx   = upd_idx;
      sel_taken = upd_taken;
      sel_tgt   = upd_target;
    end
  end

  assign tbl_raddr = drain ? sel_idx : last_raddr;

  // Saturating 2-bit counter step.
  always_comb begin
    ctr_next = tbl_rctr;
    if (sel_taken) begin
      if (tbl_rctr != 2'b11) ctr_next = tbl_rctr + 2'b01;
    end else begin
      if (tbl_rctr != 2'b00) ctr_next = tbl_rctr - 2'b01;
    end
  end

  always_comb begin
    tbl_we      = 1'b0;
    tbl_waddr   = '0;
    tbl_wctr    = 2'b00;
    tbl_wtgt_en = 1'b0;
    tbl_wtgt    = '0;
    tbl_wvalid  = 1'b0;
    if (in_init) begin
      tbl_we      = 1'b1;
      tbl_waddr   = idx;
      tbl_wctr    = 2'b01;
      tbl_wtgt_en = 1'b1;
    end else if (drain) begin
      tbl_we      = 1'b1;
      tbl_waddr   = tbl_raddr;
      tbl_wctr    = ctr_next;
      tbl_wtgt_en = sel_taken;
      tbl_wvalid  = sel_taken;
      tbl_wtgt    = sel_taken ? sel_tgt : 10'd0;
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state      <= S_START;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      last_raddr <= '0;
    end else begin
      last_raddr <= tbl_raddr;
      if (flush_req) begin
        // A write presented this cycle still lands; everything queued is dropped.
        state  <= S_INIT;
        idx    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        case (state)
          S_START: begin
            state <= S_INIT;
            idx   <= '0;
          end
          S_INIT: begin
            idx <= idx + 1'b1;
            if (idx == {IDX_W{1'b1}}) state <= S_RUN;
          end
          S_RUN: begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
              2'b10:   cnt <= cnt + 1'b1;
              2'b01:   cnt <= cnt - 1'b1;
              default: cnt <= cnt;
            endcase
          end
          default: state <= S_START;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_idx[wr_ptr]   <= upd_idx;
      q_taken[wr_ptr] <= upd_taken;
      q_tgt[wr_ptr]   <= upd_target;
    end
  end

endmodule

// File: tb/tb_bht_sched.sv
// tb_bht_sched: directed + random updates checked cycle-by-cycle against a queue/table model.
module tb_bht_sched;
  localparam int IDX_W = 6;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDX_W;
  localparam int M_START = 0, M_INIT = 1, M_RUN = 2;

  logic CLK = 1'b0;
  logic nrst = 1'b0;
  logic upd_valid = 1'b0, upd_taken = 1'b0, flush_req = 1'b0;
  logic [9:0] upd_PC = '0, upd_target = '0;
  logic upd_ready, tbl_we, tbl_wtgt_en, tbl_wvalid, pred_en;
  logic [IDX_W-1:0] tbl_raddr, tbl_waddr;
  logic [1:0] tbl_rctr, tbl_wctr;
  logic [9:0] tbl_wtgt;

  bht_sched #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nrst(nrst), .upd_valid(upd_valid), .upd_PC(upd_PC),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_ready(upd_ready),
    .flush_req(flush_req), .tbl_raddr(tbl_raddr), .tbl_rctr(tbl_rctr),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wctr(tbl_wctr),
    .tbl_wtgt_en(tbl_wtgt_en), .tbl_wtgt(tbl_wtgt), .tbl_wvalid(tbl_wvalid),
    .pred_en(pred_en)
  );

  always #5 CLK = ~CLK;

  // The table itself lives in the bench.
  logic [1:0] mem_ctr [NENT];
  logic [9:0] mem_tgt [NENT];
  logic       mem_val [NENT];
  always @(posedge CLK) begin
    if (tbl_we) begin
      mem_ctr[tbl_waddr] <= tbl_wctr;
      if (tbl_wtgt_en) begin
        mem_tgt[tbl_waddr] <= tbl_wtgt;
        mem_val[tbl_waddr] <= tbl_wvalid;
      end
    end
  end
  assign tbl_rctr = mem_ctr[tbl_raddr];

  typedef struct packed {
    logic [9:0] pc;
    logic       taken;
    logic [9:0] tgt;
  } upd_t;

  int   errors = 0;
  int   checks = 0;
  int   ph, m_idx, m_last;
  upd_t q[$];
  int   ref_ctr [NENT];
  int   ref_tgt [NENT];
  int   ref_val [NENT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = M_START;
    m_idx = 0;
    m_last = 0;
    q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_we", tbl_we, 0);
    chk("rst_waddr", tbl_waddr, 0);
    chk("rst_raddr", tbl_raddr, 0);
    chk("rst_wctr", tbl_wctr, 0);
    chk("rst_wtgt_en", tbl_wtgt_en, 0);
    chk("rst_wtgt", tbl_wtgt, 0);
    chk("rst_wvalid", tbl_wvalid, 0);
    chk("rst_pred_en", pred_en, 0);
    chk("rst_upd_ready", upd_ready, 0);
  endtask

  // Compare one cycle of DUT outputs, then advance the model across the edge.
  task automatic model_cycle();
    upd_t inc, u;
    bit have, byp, acc, e_we, e_ten, e_val, rdy;
    int a, c, e_waddr, e_ctr, e_tgt;
    inc = '{pc: upd_PC, taken: upd_taken, tgt: upd_target};
    u = '0;
    have = 0; byp = 0; e_we = 0; e_ten = 0; e_val = 0;
    e_waddr = 0; e_ctr = 0; e_tgt = 0; a = m_last;
    rdy = (ph == M_RUN) && (q.size() < DEPTH) && !flush_req;
    acc = upd_valid && rdy;
    chk("upd_ready", upd_ready, rdy);
    chk("pred_en", pred_en, ph == M_RUN);
    if (ph == M_INIT) begin
      e_we = 1; e_waddr = m_idx; e_ctr = 1; e_ten = 1; e_tgt = 0; e_val = 0;
    end else if (ph == M_RUN && q.size() > 0) begin
      u = q[0]; have = 1;
    end
`ifdef BHT_SCHED_BYPASS_EN
    else if (acc) begin
      u = inc; have = 1; byp = 1;
    end
`endif
    if (have) begin
      a = int'(u.pc) % NENT;
      c = ref_ctr[a];
      e_ctr = u.taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      e_we = 1; e_waddr = a; e_ten = u.taken; e_val = u.taken;
      e_tgt = u.taken ? int'(u.tgt) : 0;
    end
    chk("tbl_we", tbl_we, e_we);
    if (ph == M_RUN) chk("tbl_raddr", tbl_raddr, a);
    if (e_we) begin
      chk("tbl_waddr", tbl_waddr, e_waddr);
      chk("tbl_wctr", tbl_wctr, e_ctr);
      chk("tbl_wtgt_en", tbl_wtgt_en, e_ten);
      if (e_ten) begin
        chk("tbl_wvalid", tbl_wvalid, e_val);
        chk("tbl_wtgt", tbl_wtgt, e_tgt);
      end
    end
    if (e_we) begin
      ref_ctr[e_waddr] = e_ctr;
      if (e_ten) begin
        ref_tgt[e_waddr] = e_tgt;
        ref_val[e_waddr] = e_val;
      end
    end
    if (have) m_last = a;
    if (flush_req) begin
      ph = M_INIT; m_idx = 0; q.delete();
    end else if (ph == M_START) begin
      ph = M_INIT; m_idx = 0;
    end else if (ph == M_INIT) begin
      if (m_idx == NENT - 1) ph = M_RUN;
      else m_idx++;
    end else begin
      if (have && !byp) void'(q.pop_front());
      if (acc && !byp) q.push_back(inc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [9:0] pc, input logic tk, input logic [9:0] tgt);
    upd_valid = 1'b1; upd_PC = pc; upd_taken = tk; upd_target = tgt;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge CLK);
    #1;
    nrst = 1'b1;

    // Abort the first sweep at idx 30 with an asynchronous reset.
    repeat (1 + 30) tick();
    chk("pre_reset_waddr", tbl_waddr, 30);
    #2 nrst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge CLK);
    #1 nrst = 1'b1;
    repeat (1 + NENT) tick();
    chk("run_after_sweep", pred_en, 1);

    // Saturation and target-write cases.
    send(10'h005, 1'b1, 10'h0AA);
    tick();
    send(10'h005, 1'b1, 10'h120);
    tick();
    chk("idx5_ctr", mem_ctr[5], 3);
    chk("idx5_tgt", mem_tgt[5], 10'h120);
    send(10'h005, 1'b1, 10'h200);
    send(10'h007, 1'b0, 10'h3FF);
    tick();
    send(10'h007, 1'b0, 10'h111);
    tick();
    chk("idx5_sat_hi", mem_ctr[5], 3);
    chk("idx7_sat_lo", mem_ctr[7], 0);
    chk("idx7_valid", mem_val[7], 0);

    // Back-to-back updates, then flush, then a flush inside the new sweep.
    upd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_PC = 10'(8 + i); upd_taken = 1'b1; upd_target = 10'(16 * i + 1);
      tick();
    end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    upd_valid = 1'b0;
    repeat (10) tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (NENT + 2) tick();

    // Random traffic on a few hot indices to exercise saturation.
    for (int n = 0; n < 2500; n++) begin
      upd_valid  = 1'($urandom);
      upd_taken  = 1'($urandom);
      upd_PC     = {4'($urandom), 6'($urandom_range(0, 7))};
      upd_target = 10'($urandom);
      flush_req  = ($urandom_range(0, 399) == 0);
      tick();
    end
    upd_valid = 1'b0;
    flush_req = 1'b0;
    repeat (NENT + 8) tick();

    for (int i = 0; i < NENT; i++) begin
      chk($sformatf("final_ctr_%0d", i), mem_ctr[i], ref_ctr[i]);
      chk($sformatf("final_val_%0d", i), mem_val[i], ref_val[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
